// File: rtl/serial_rx_pkg.sv
// Shared types for the serial frame receiver.
// Receiver FSM states and serial line levels.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_rx_outbuf.sv
// One-entry valid/ready holding register.
// Drops a new word and flags overflow when full and not drained.
module serial_rx_outbuf #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] dIn,
    input  logic              pIn,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] dataOut,
    output logic              parityErr,
    output logic              overflow
);

    logic canLoad;

    // A slot is free when empty or being drained this cycle.
    assign canLoad = !valid || ready;

    // Hold register, valid flag and overflow pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid     <= 1'b0;
            dataOut   <= '0;
            parityErr <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= load && !canLoad;
            if (load && canLoad) begin
                valid     <= 1'b1;
                dataOut   <= dIn;
                parityErr <= pIn;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start detect, LSB-first shift,
// optional parity, stop check and buffered word output.
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              serIn,
    output logic              shEn,
    output logic              Done,
    output logic [DATA_W-1:0] dataOut,
    output logic              valid,
    input  logic              ready,
    output logic              parityErr,
    output logic              frameErr,
    output logic              overflow
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    rx_state_t state, nextState;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shReg;
    logic              parAcc;
    logic              parErr;
    logic              frameGood;

    assign frameGood = (state == STOP) && (serIn == IDLE_LEVEL);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode: one serial bit per clock.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:   if (serIn == START_LEVEL) nextState = DATA;
            DATA:   if (cnt == LAST)
                        nextState = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: nextState = STOP;
            STOP:   nextState = IDLE;
        endcase
    end

    // Bit counter, shifter, parity and end-of-frame pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            shReg    <= '0;
            parAcc   <= 1'b0;
            parErr   <= 1'b0;
            shEn     <= 1'b0;
            Done     <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            shEn     <= (nextState == DATA);
            Done     <= (state == STOP);
            frameErr <= (state == STOP) && (serIn != IDLE_LEVEL);
            unique case (state)
                IDLE: begin
                    cnt    <= '0;
                    parAcc <= 1'b0;
                    parErr <= 1'b0;
                end
                DATA: begin
                    shReg  <= {serIn, shReg[DATA_W-1:1]};
                    cnt    <= cnt + 1'b1;
                    parAcc <= parAcc ^ serIn;
                end
                PARITY: parErr <= ((parAcc ^ serIn) != ODD);
                STOP: ;
            endcase
        end
    end

    serial_rx_outbuf #(
        .DATA_W(DATA_W)
    ) uOutBuf (
        .CLK      (CLK),
        .RST      (RST),
        .load     (frameGood),
        .dIn      (shReg),
        .pIn      (parErr),
        .ready    (ready),
        .valid    (valid),
        .dataOut  (dataOut),
        .parityErr(parityErr),
        .overflow (overflow)
    );

endmodule
